flex_counter_updown: RTL

- Parametrised successor to the lab flex counter: N-bit up/down counter with programmable rollover value, parallel load, and three terminal modes (wrap, saturate, one-shot).
- One-shot mode uses a small control FSM that raises `done` and freezes the count until re-armed.
- Intended as the timing/bit-count primitive for the next generation of serial RX/TX and timer blocks.

---
 rtl/flex_counter_pkg.sv | 17 +
 rtl/flex_counter_next_val.sv | 62 ++++++
 rtl/flex_counter_updown.sv | 117 +++++++++++
 3 files changed

// File: rtl/flex_counter_pkg.sv
// Shared types for the flex up/down counter: terminal-mode encoding and
// one-shot control FSM states.
package flex_counter_pkg;

    typedef enum logic [1:0] {
        MODE_WRAP    = 2'b00,
        MODE_SAT     = 2'b01,
        MODE_ONESHOT = 2'b10,
        MODE_RSVD    = 2'b11
    } mode_t;

    typedef enum logic [0:0] {
        ST_COUNT = 1'b0,
        ST_DONE  = 1'b1
    } state_t;

endpackage

// File: rtl/flex_counter_next_val.sv
// Combinational next-count and flag logic for one enabled count step,
// covering wrap, saturate and one-shot terminal behaviour in both directions.
module flex_counter_next_val
    import flex_counter_pkg::*;
#(
    parameter int NUM_CNT_BITS = 4,
    parameter int RESTART_VAL  = 1
) (
    input  logic [NUM_CNT_BITS-1:0] count,
    input  logic [NUM_CNT_BITS-1:0] rollover_val,
    input  logic                    count_down,
    input  mode_t                   mode,
    output logic [NUM_CNT_BITS-1:0] next_count,
    output logic                    next_rollover,
    output logic                    next_zero,
    output logic                    terminal_hit
);

    localparam logic [NUM_CNT_BITS-1:0] CNT_ZERO    = {NUM_CNT_BITS{1'b0}};
    localparam logic [NUM_CNT_BITS-1:0] CNT_ONE     = NUM_CNT_BITS'(32'd1);
    localparam logic [NUM_CNT_BITS-1:0] CNT_RESTART = NUM_CNT_BITS'(RESTART_VAL);

    // Next count value plus the flags it implies and the one-shot terminal condition
    always_comb begin
        next_count    = count;
        next_rollover = 1'b0;
        terminal_hit  = 1'b0;
        if (count_down) begin
            if (count != CNT_ZERO) begin
                next_count = count - CNT_ONE;
            end else begin
                case (mode)
                    MODE_WRAP, MODE_RSVD: next_count = rollover_val;
                    MODE_SAT, MODE_ONESHOT: next_count = CNT_ZERO;
                    default: next_count = rollover_val;
                endcase
            end
            next_rollover = (next_count == rollover_val);
            terminal_hit  = (next_count == CNT_ZERO);
        end else if (rollover_val == CNT_ZERO) begin
            // A zero terminal pins up-counting at 0 and never reports rollover
            next_count    = CNT_ZERO;
            next_rollover = 1'b0;
            terminal_hit  = 1'b0;
        end else begin
            if (count < rollover_val) begin
                next_count = count + CNT_ONE;
            end else begin
                case (mode)
                    MODE_WRAP, MODE_RSVD: next_count = CNT_RESTART;
                    MODE_SAT: next_count = rollover_val;
                    MODE_ONESHOT: next_count = count;
                    default: next_count = CNT_RESTART;
                endcase
            end
            next_rollover = (next_count == rollover_val);
            terminal_hit  = next_rollover;
        end
        next_zero = (next_count == CNT_ZERO);
    end

endmodule

// File: rtl/flex_counter_updown.sv
// N-bit up/down counter with programmable rollover, parallel load and
// wrap/saturate/one-shot terminal modes; all outputs come straight from flops.
module flex_counter_updown
    import flex_counter_pkg::*;
#(
    parameter int NUM_CNT_BITS = 4,
    parameter int RESTART_VAL  = 1
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic                    clear,
    input  logic                    count_enable,
    input  logic                    count_down,
    input  logic                    load,
    input  logic [NUM_CNT_BITS-1:0] load_val,
    input  logic [NUM_CNT_BITS-1:0] rollover_val,
    input  logic [1:0]              mode,
    output logic [NUM_CNT_BITS-1:0] count_out,
    output logic                    rollover_flag,
    output logic                    zero_flag,
    output logic                    done
);

    localparam logic [NUM_CNT_BITS-1:0] CNT_ZERO = {NUM_CNT_BITS{1'b0}};

    mode_t                   mode_s;
    state_t                  state_r, state_nxt_s;
    logic [NUM_CNT_BITS-1:0] count_r, count_nxt_s, step_count_s;
    logic                    rollover_r, rollover_nxt_s, step_rollover_s;
    logic                    zero_r, zero_nxt_s, step_zero_s;
    logic                    done_r, done_nxt_s;
    logic                    terminal_hit_s;

    assign mode_s = mode_t'(mode);

    flex_counter_next_val #(
        .NUM_CNT_BITS (NUM_CNT_BITS),
        .RESTART_VAL  (RESTART_VAL)
    ) u_next_val (
        .count         (count_r),
        .rollover_val  (rollover_val),
        .count_down    (count_down),
        .mode          (mode_s),
        .next_count    (step_count_s),
        .next_rollover (step_rollover_s),
        .next_zero     (step_zero_s),
        .terminal_hit  (terminal_hit_s)
    );

    // Next-state selection: clear > load > one-shot freeze > count > hold
    always_comb begin
        state_nxt_s    = state_r;
        count_nxt_s    = count_r;
        rollover_nxt_s = rollover_r;
        zero_nxt_s     = zero_r;
        done_nxt_s     = done_r;
        if (clear) begin
            state_nxt_s    = ST_COUNT;
            count_nxt_s    = CNT_ZERO;
            rollover_nxt_s = 1'b0;
            zero_nxt_s     = 1'b1;
            done_nxt_s     = 1'b0;
        end else if (load) begin
            state_nxt_s    = ST_COUNT;
            count_nxt_s    = load_val;
            rollover_nxt_s = (load_val == rollover_val);
            zero_nxt_s     = (load_val == CNT_ZERO);
            done_nxt_s     = 1'b0;
        end else if (state_r == ST_DONE) begin
            // Count is frozen; leaving one-shot mode re-arms on this edge
            if (mode_s != MODE_ONESHOT) begin
                state_nxt_s = ST_COUNT;
                done_nxt_s  = 1'b0;
            end else begin
                state_nxt_s = ST_DONE;
                done_nxt_s  = 1'b1;
            end
        end else if (count_enable) begin
            count_nxt_s    = step_count_s;
            rollover_nxt_s = step_rollover_s;
            zero_nxt_s     = step_zero_s;
            if ((mode_s == MODE_ONESHOT) && terminal_hit_s) begin
                state_nxt_s = ST_DONE;
                done_nxt_s  = 1'b1;
            end else begin
                state_nxt_s = ST_COUNT;
                done_nxt_s  = 1'b0;
            end
        end else begin
            state_nxt_s = state_r;
            count_nxt_s = count_r;
        end
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_r    <= ST_COUNT;
            count_r    <= CNT_ZERO;
            rollover_r <= 1'b0;
            zero_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            count_r    <= count_nxt_s;
            rollover_r <= rollover_nxt_s;
            zero_r     <= zero_nxt_s;
            done_r     <= done_nxt_s;
        end
    end

    assign count_out     = count_r;
    assign rollover_flag = rollover_r;
    assign zero_flag     = zero_r;
    assign done          = done_r;

endmodule
